// File: rtl/sdram_page_scheduler_if.sv
// Bus between the page scheduler, the FIFO bank and the SDRAM page controller.
// The master side is the scheduler. The slave side is the FIFO/controller environment.
interface sdram_page_scheduler_if #(
    parameter int NCH   = 4,
    parameter int LVL_W = 11,
    parameter int ROW_W = 15
);
    logic [NCH-1:0]       ch_enable;
    logic [NCH*LVL_W-1:0] ch_level;
    logic                 fault_clr;
    logic                 cmd_pagewrite;
    logic                 cmd_pageread;
    logic                 cmd_ack;
    logic                 cmd_done;
    logic [ROW_W-1:0]     rowaddr;
    logic [NCH-1:0]       grant;
    logic                 fault_timeout;
    logic [NCH-1:0]       fault_ch;

    modport master (
        input  ch_enable, ch_level, fault_clr, cmd_ack, cmd_done,
        output cmd_pagewrite, cmd_pageread, rowaddr, grant, fault_timeout, fault_ch
    );

    modport slave (
        output ch_enable, ch_level, fault_clr, cmd_ack, cmd_done,
        input  cmd_pagewrite, cmd_pageread, rowaddr, grant, fault_timeout, fault_ch
    );
endinterface

// File: rtl/sdram_page_scheduler.sv
// Round-robin scheduler sharing one full-page SDRAM controller between NCH FIFO channels.
// Each channel owns a private, wrapping row region. A page is requested in ACKWAIT, runs in BUSY,
// and a watchdog returns to IDLE and flags the channel if ack or done never arrives.
module sdram_page_scheduler #(
    parameter int             NCH        = 4,
    parameter logic [NCH-1:0] DIR_MASK   = 4'b0101,
    parameter int             LVL_W      = 11,
    parameter int             FIFO_WORDS = 2048,
    parameter int             PAGE_WORDS = 512,
    parameter int             ROW_W      = 15,
    parameter int             TIMEOUT    = 4095
) (
    input  logic                  clk,
    input  logic                  reset_n,
    sdram_page_scheduler_if.master bus
);
    localparam int IDX_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int REGION = (1 << ROW_W) / NCH;
    localparam int TMO_W  = $clog2(TIMEOUT + 1);

    localparam logic [LVL_W-1:0] WR_THR      = LVL_W'(PAGE_WORDS);
    localparam logic [LVL_W-1:0] RD_THR      = LVL_W'(FIFO_WORDS - PAGE_WORDS);
    localparam logic [ROW_W-1:0] REGION_LAST = ROW_W'(REGION - 1);
    localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACKWAIT = 2'd1,
        S_BUSY    = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [IDX_W-1:0]   cur_ch_q;
    logic               dir_wr_q;
    logic [NCH-1:0]     grant_q;
    logic [ROW_W-1:0]   rowaddr_q;
    logic [TMO_W-1:0]   tmo_cnt_q;
    logic               fault_timeout_q;
    logic [NCH-1:0]     fault_ch_q;

    logic [NCH-1:0]     elig;
    logic [ROW_W-1:0]   row_ptr  [NCH];
    logic [ROW_W-1:0]   row_base [NCH];

    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   rr_next;
    int                 cand;

    logic               take_grant;
    logic               ack_evt;
    logic               finish_evt;
    logic               tmo_evt;
    logic               tmo_last;

    assign tmo_last = (tmo_cnt_q == TMO_LAST);

    // Per-channel eligibility, region base and row pointer.
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic [LVL_W-1:0] lvl;
        logic [ROW_W-1:0] ptr_q;

        assign lvl          = bus.ch_level[gi*LVL_W +: LVL_W];
        assign row_base[gi] = ROW_W'(gi * REGION);
        assign row_ptr[gi]  = ptr_q;

        if (DIR_MASK[gi]) begin : g_wr
            // Write channel needs a full page waiting in its FIFO.
            assign elig[gi] = bus.ch_enable[gi] && (lvl >= WR_THR);
        end else begin : g_rd
            // Read channel needs room for a full page in its FIFO.
            assign elig[gi] = bus.ch_enable[gi] && (lvl <= RD_THR);
        end

        // Advance this channel's row only when the controller accepted its page.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                ptr_q <= '0;
            end else if (ack_evt && (cur_ch_q == IDX_W'(gi))) begin
                ptr_q <= (ptr_q == REGION_LAST) ? '0 : ptr_q + 1'b1;
            end
        end
    end

    // Round-robin search: the lowest offset from rr_ptr that is eligible wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int i = NCH - 1; i >= 0; i--) begin
            cand = int'(rr_ptr_q) + i;
            if (cand >= NCH) begin
                cand = cand - NCH;
            end
            if (elig[IDX_W'(cand)]) begin
                pick_valid = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
        rr_next = (pick_idx == IDX_W'(NCH - 1)) ? '0 : pick_idx + 1'b1;
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and the events that steer the datapath.
    always_comb begin
        state_d    = state_q;
        take_grant = 1'b0;
        ack_evt    = 1'b0;
        finish_evt = 1'b0;
        tmo_evt    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    take_grant = 1'b1;
                    state_d    = S_ACKWAIT;
                end
            end
            S_ACKWAIT: begin
                // A lone cmd_done here is ignored; ack has priority over the watchdog.
                if (bus.cmd_ack) begin
                    ack_evt = 1'b1;
                    if (bus.cmd_done) begin
                        finish_evt = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        state_d = S_BUSY;
                    end
                end else if (tmo_last) begin
                    tmo_evt = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (bus.cmd_done) begin
                    finish_evt = 1'b1;
                    state_d    = S_IDLE;
                end else if (tmo_last) begin
                    tmo_evt = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Command strobes exist only while waiting for the controller to accept.
    always_comb begin
        bus.cmd_pagewrite = (state_q == S_ACKWAIT) && dir_wr_q;
        bus.cmd_pageread  = (state_q == S_ACKWAIT) && !dir_wr_q;
    end

    // Grant, row, direction, round-robin pointer and watchdog counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_q   <= '0;
            rowaddr_q <= '0;
            dir_wr_q  <= 1'b0;
            cur_ch_q  <= '0;
            rr_ptr_q  <= '0;
            tmo_cnt_q <= '0;
        end else begin
            if (take_grant) begin
                grant_q   <= {{(NCH-1){1'b0}}, 1'b1} << pick_idx;
                rowaddr_q <= row_base[pick_idx] + row_ptr[pick_idx];
                dir_wr_q  <= DIR_MASK[pick_idx];
                cur_ch_q  <= pick_idx;
                rr_ptr_q  <= rr_next;
                tmo_cnt_q <= '0;
            end else if (ack_evt) begin
                tmo_cnt_q <= '0;
            end else if (state_q != S_IDLE) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
            if (finish_evt || tmo_evt) begin
                grant_q <= '0;
            end
        end
    end

    // Sticky fault flags; a new fault outranks a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fault_timeout_q <= 1'b0;
            fault_ch_q      <= '0;
        end else begin
            fault_timeout_q <= tmo_evt | (fault_timeout_q & ~bus.fault_clr);
            fault_ch_q      <= (bus.fault_clr ? '0 : fault_ch_q) | (tmo_evt ? grant_q : '0);
        end
    end

    assign bus.grant         = grant_q;
    assign bus.rowaddr       = rowaddr_q;
    assign bus.fault_timeout = fault_timeout_q;
    assign bus.fault_ch      = fault_ch_q;
endmodule

// File: tb/tb_sdram_page_scheduler.sv
// Directed plus randomized bench for the SDRAM page scheduler.
// A transaction-level model predicts which channel wins, which row it uses and the fault flags.
`timescale 1ns/1ps
module tb_sdram_page_scheduler;
    localparam int NCH     = 4;
    localparam int LVL_W   = 11;
    localparam int ROW_W   = 15;
    localparam int TIMEOUT = 4095;
    localparam int REGION  = (1 << ROW_W) / NCH;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    sdram_page_scheduler_if #(.NCH(NCH), .LVL_W(LVL_W), .ROW_W(ROW_W)) bus ();

    sdram_page_scheduler #(
        .NCH(NCH), .DIR_MASK(4'b0101), .LVL_W(LVL_W), .FIFO_WORDS(2048),
        .PAGE_WORDS(512), .ROW_W(ROW_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Reference model state.
    bit is_wr [NCH] = '{1'b1, 1'b0, 1'b1, 1'b0};
    bit m_en  [NCH];
    int m_lvl [NCH];
    int m_row [NCH];
    int m_rr;

    int checks   = 0;
    int failures = 0;
    int pages    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply();
        for (int k = 0; k < NCH; k++) begin
            bus.ch_enable[k]                 = m_en[k];
            bus.ch_level[k*LVL_W +: LVL_W]   = LVL_W'(m_lvl[k]);
        end
    endtask

    function automatic bit eligible(input int k);
        if (!m_en[k]) return 1'b0;
        if (is_wr[k]) return m_lvl[k] >= 512;
        return m_lvl[k] <= 2048 - 512;
    endfunction

    function automatic int predict();
        for (int i = 0; i < NCH; i++) begin
            if (eligible((m_rr + i) % NCH)) return (m_rr + i) % NCH;
        end
        return -1;
    endfunction

    function automatic int rand_lvl();
        case ($urandom_range(0, 6))
            0: return 511;
            1: return 512;
            2: return 1536;
            3: return 1537;
            4: return 0;
            5: return 2047;
            default: return int'($urandom_range(0, 2047));
        endcase
    endfunction

    task automatic set_all(input bit en, input int lvl);
        for (int k = 0; k < NCH; k++) begin
            m_en[k]  = en;
            m_lvl[k] = lvl;
        end
    endtask

    // Async reset: outputs must clear without waiting for a clock edge.
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_grant", bus.grant, 0);
        chk("rst_row", bus.rowaddr, 0);
        chk("rst_cmd", {bus.cmd_pagewrite, bus.cmd_pageread}, 0);
        chk("rst_ftmo", bus.fault_timeout, 0);
        chk("rst_fch", bus.fault_ch, 0);
        step();
        step();
        reset_n = 1'b1;
        m_rr = 0;
        for (int k = 0; k < NCH; k++) m_row[k] = 0;
    endtask

    // One complete page; DUT must be in IDLE with inputs applied on entry.
    task automatic do_page(input int ack_dly, input int done_dly, input bit same,
                           input bit drop_en, input bit verbose);
        int k;
        int exp_row;
        k = predict();
        if (k < 0) begin
            step();
            chk("idle_grant", bus.grant, 0);
            return;
        end
        exp_row = k * REGION + m_row[k];
        step();
        chk("grant", bus.grant, 1 << k);
        chk("rowaddr", bus.rowaddr, exp_row);
        chk("cmd_wr", bus.cmd_pagewrite, is_wr[k]);
        chk("cmd_rd", bus.cmd_pageread, !is_wr[k]);
        m_rr = (k + 1) % NCH;
        if (drop_en) begin
            set_all(1'b0, 0);
            apply();
        end
        for (int i = 0; i < ack_dly; i++) begin
            bus.cmd_done = (i == 0);
            step();
            chk("cmd_held", {bus.cmd_pagewrite, bus.cmd_pageread}, is_wr[k] ? 2 : 1);
        end
        bus.cmd_ack  = 1'b1;
        bus.cmd_done = same;
        step();
        bus.cmd_ack  = 1'b0;
        bus.cmd_done = 1'b0;
        m_row[k] = (m_row[k] + 1) % REGION;
        chk("cmd_off", {bus.cmd_pagewrite, bus.cmd_pageread}, 0);
        if (!same) begin
            chk("grant_busy", bus.grant, 1 << k);
            chk("row_busy", bus.rowaddr, exp_row);
            for (int i = 0; i < done_dly; i++) begin
                step();
                chk("grant_hold", bus.grant, 1 << k);
            end
            bus.cmd_done = 1'b1;
            step();
            bus.cmd_done = 1'b0;
        end
        chk("grant_idle", bus.grant, 0);
        chk("cmd_idle", {bus.cmd_pagewrite, bus.cmd_pageread}, 0);
        pages++;
        if (verbose) begin
            $display("page %0d ch=%0d dir=%s row=0x%04h ack_dly=%0d same=%0d drop_en=%0d",
                     pages, k, is_wr[k] ? "wr" : "rd", exp_row, ack_dly, same, drop_en);
        end
    endtask

    initial begin
        bus.ch_enable = '0;
        bus.ch_level  = '0;
        bus.fault_clr = 1'b0;
        bus.cmd_ack   = 1'b0;
        bus.cmd_done  = 1'b0;
        set_all(1'b0, 0);
        do_reset();

        // Single write channel at the exact threshold.
        m_en[0] = 1'b1; m_lvl[0] = 512; apply();
        do_page(1, 2, 1'b0, 1'b0, 1'b1);

        // All four eligible: order 0,1,2,3,0 from a fresh reset.
        set_all(1'b0, 0); apply();
        do_reset();
        set_all(1'b1, 0); m_lvl[0] = 1024; m_lvl[2] = 1024; apply();
        for (int i = 0; i < 5; i++) begin
            do_page(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b1);
        end

        // Just outside the thresholds: nothing may be granted.
        set_all(1'b0, 0);
        m_en[0] = 1'b1; m_lvl[0] = 511;
        m_en[1] = 1'b1; m_lvl[1] = 1537;
        apply();
        for (int i = 0; i < 6; i++) begin
            step();
            chk("no_grant", bus.grant, 0);
            chk("no_cmd", {bus.cmd_pagewrite, bus.cmd_pageread}, 0);
        end
        $display("boundary levels wr=511 rd=1537 held 6 cycles without grant");

        // Read channel exactly at its threshold; then drop enable mid-page.
        m_en[0] = 1'b0; m_lvl[1] = 1536; apply();
        do_page(2, 1, 1'b0, 1'b0, 1'b1);
        m_en[1] = 1'b1; m_lvl[1] = 0; apply();
        do_page(1, 3, 1'b0, 1'b1, 1'b1);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < NCH; k++) begin
                m_en[k]  = ($urandom_range(0, 3) != 0);
                m_lvl[k] = rand_lvl();
            end
            apply();
            if (predict() < 0) begin
                for (int i = 0; i < 3; i++) begin
                    step();
                    chk("rand_idle", bus.grant, 0);
                end
                $display("random idle window levels=%0d,%0d,%0d,%0d", m_lvl[0], m_lvl[1], m_lvl[2], m_lvl[3]);
            end else begin
                do_page(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                        bit'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 1'b1);
            end
        end

        // Ack withheld: watchdog fault on channel 0, row is reused afterwards.
        set_all(1'b0, 0); m_en[0] = 1'b1; m_lvl[0] = 1024; apply();
        begin
            int exp_row;
            exp_row = m_row[0];
            m_rr = 0;
            step();
            chk("tmo_grant", bus.grant, 1);
            chk("tmo_row", bus.rowaddr, exp_row);
            repeat (TIMEOUT - 1) step();
            chk("tmo_cmd_held", bus.cmd_pagewrite, 1);
            chk("tmo_not_yet", bus.fault_timeout, 0);
            step();
            m_rr = 1;
            chk("tmo_cmd_off", {bus.cmd_pagewrite, bus.cmd_pageread}, 0);
            chk("tmo_grant_off", bus.grant, 0);
            chk("tmo_flag", bus.fault_timeout, 1);
            chk("tmo_fch", bus.fault_ch, 4'b0001);
            $display("timeout ch=0 row=0x%04h fault_ch=%b", exp_row, bus.fault_ch);
        end
        do_page(0, 1, 1'b0, 1'b0, 1'b1);
        chk("tmo_sticky", bus.fault_timeout, 1);
        set_all(1'b0, 0); apply();
        bus.fault_clr = 1'b1;
        step();
        bus.fault_clr = 1'b0;
        chk("clr_ftmo", bus.fault_timeout, 0);
        chk("clr_fch", bus.fault_ch, 0);

        // Wrap channel 1's region using ack+done in the same cycle.
        m_en[1] = 1'b1; m_lvl[1] = 0; apply();
        while (m_row[1] != REGION - 1) begin
            do_page(0, 0, 1'b1, 1'b0, 1'b0);
        end
        $display("channel 1 advanced to row pointer 0x%04h", m_row[1]);
        do_page(0, 0, 1'b1, 1'b0, 1'b1);
        do_page(0, 1, 1'b0, 1'b0, 1'b1);

        // Reset asserted while BUSY.
        set_all(1'b0, 0); m_en[0] = 1'b1; m_lvl[0] = 2047; apply();
        step();
        chk("rb_grant", bus.grant, 1 << predict());
        bus.cmd_ack = 1'b1;
        step();
        bus.cmd_ack = 1'b0;
        #2;
        do_reset();
        do_page(1, 1, 1'b0, 1'b0, 1'b1);

        set_all(1'b0, 0); apply();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
